// File: rtl/epc_pkg.sv
// epc_pkg: shared EPC stack defaults and pointer/level width derivation
package epc_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  function automatic int ptr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int lvl_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/epc_stack_if.sv
// epc_stack_if: push/pop/write controls and status of the nested EPC stack
interface epc_stack_if
  import epc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic exc_push, eret_pop, sw_we, flag_clr;
  logic [WIDTH-1:0] pc_in, din, dout;
  logic [lvl_w(DEPTH)-1:0] level;
  logic empty, full, ovf, udf;
  modport master (
    output exc_push, pc_in, eret_pop, sw_we, din, flag_clr,
    input  dout, level, empty, full, ovf, udf
  );
  modport slave (
    input  exc_push, pc_in, eret_pop, sw_we, din, flag_clr,
    output dout, level, empty, full, ovf, udf
  );
endinterface

// File: rtl/epc_stack.sv
// epc_stack: circular nested-exception PC stack; define EPC_STACK_STATUS_EN to build sticky ovf/udf flags
module epc_stack
  import epc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic reset,
  epc_stack_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] top, nxt;
  logic [LW-1:0] level;
  logic empty, full, push, pop, wr;
  assign nxt   = top + 1'b1;
  assign empty = level == '0;
  assign full  = level == LW'(DEPTH);
  assign push  = bus.exc_push;
  assign pop   = !push && bus.eret_pop && !empty;
  assign wr    = !push && !bus.eret_pop && bus.sw_we;
  // a write into an empty stack behaves as a push of din
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem   <= '{default: '0};
      top   <= '0;
      level <= '0;
    end else if (push || (wr && empty)) begin
      mem[nxt] <= push ? bus.pc_in : bus.din;
      top      <= nxt;
      level    <= full ? level : level + 1'b1;
    end else if (pop) begin
      top   <= top - 1'b1;
      level <= level - 1'b1;
    end else if (wr) begin
      mem[top] <= bus.din;
    end
  assign bus.dout  = empty ? '0 : mem[top];
  assign bus.level = level;
  assign bus.empty = empty;
  assign bus.full  = full;
`ifdef EPC_STACK_STATUS_EN
  logic ovf, udf;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (push && full) || (ovf && !bus.flag_clr);
      udf <= (!push && bus.eret_pop && empty) || (udf && !bus.flag_clr);
    end
  assign bus.ovf = ovf;
  assign bus.udf = udf;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif
endmodule

// File: tb/tb_epc_stack.sv
// tb_epc_stack: directed checks of the EPC stack, expectations follow EPC_STACK_STATUS_EN
module tb_epc_stack;
`ifdef EPC_STACK_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  epc_stack_if #(.WIDTH(32), .DEPTH(4)) bus ();
  epc_stack #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit push, input logic [31:0] pc, input bit pop, input bit we,
                      input logic [31:0] d, input bit clr);
    bus.exc_push = push;
    bus.pc_in    = pc;
    bus.eret_pop = pop;
    bus.sw_we    = we;
    bus.din      = d;
    bus.flag_clr = clr;
    @(posedge clk);
    #1;
    bus.exc_push = 1'b0;
    bus.eret_pop = 1'b0;
    bus.sw_we    = 1'b0;
    bus.flag_clr = 1'b0;
  endtask
  task automatic push(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic pop();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask
  initial begin
    bus.exc_push = 1'b0;
    bus.pc_in    = '0;
    bus.eret_pop = 1'b0;
    bus.sw_we    = 1'b0;
    bus.din      = '0;
    bus.flag_clr = 1'b0;
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dout", bus.dout, 32'h0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_udf", 32'(bus.udf), 32'd0);
    push(32'h3000);
    push(32'h3010);
    check("p2_level", 32'(bus.level), 32'd2);
    check("p2_dout", bus.dout, 32'h3010);
    pop();
    check("pop1_dout", bus.dout, 32'h3000);
    pop();
    check("pop2_empty", 32'(bus.empty), 32'd1);
    check("pop2_dout", bus.dout, 32'h0);
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(4 * i));
    check("ov_full", 32'(bus.full), 32'd1);
    check("ov_ovf", 32'(bus.ovf), 32'(STAT));
    check("ov_level", 32'(bus.level), 32'd4);
    check("ov_dout0", bus.dout, 32'h110);
    pop();
    check("ov_dout1", bus.dout, 32'h10C);
    pop();
    check("ov_dout2", bus.dout, 32'h108);
    pop();
    check("ov_dout3", bus.dout, 32'h104);
    pop();
    check("ov_drain", 32'(bus.level), 32'd0);
    check("ov_sticky", 32'(bus.ovf), 32'(STAT));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("ovf_clr", 32'(bus.ovf), 32'd0);
    pop();
    check("udf_set", 32'(bus.udf), 32'(STAT));
    check("udf_level", 32'(bus.level), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("udf_clr", 32'(bus.udf), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("udf_win", 32'(bus.udf), 32'(STAT));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
    check("swe_level", 32'(bus.level), 32'd1);
    check("swe_dout", bus.dout, 32'hBFC0_0380);
    step(1'b0, '0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    check("sw_level", 32'(bus.level), 32'd1);
    check("sw_dout", bus.dout, 32'h1234_5678);
    step(1'b1, 32'h200, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("pri_level", 32'(bus.level), 32'd2);
    check("pri_dout", bus.dout, 32'h200);
    push(32'h300);
    check("ar_pre", 32'(bus.level), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("ar_level", 32'(bus.level), 32'd0);
    check("ar_dout", bus.dout, 32'h0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_ovf", 32'(bus.ovf), 32'd0);
    check("ar_udf", 32'(bus.udf), 32'd0);
    #3 reset = 1'b0;
    bus.exc_push = 1'b1;
    bus.pc_in    = 32'h400;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.exc_push = 1'b0;
    check("mid_level", 32'(bus.level), 32'd0);
    check("mid_dout", bus.dout, 32'h0);
    push(32'h500);
    check("post_dout", bus.dout, 32'h500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
